// File: rtl/hazard_forward_unit.sv
// Forwarding select and load-use stall control for the 5-stage MIPS pipe.
// Optional HFU_STATS_EN adds saturating stall/forward activity counters.
module hazard_forward_unit #(
  parameter int LOAD_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] IF_ID_Rs,
  input  logic [4:0] IF_ID_Rt,
  input  logic [4:0] ID_EX_Rs,
  input  logic [4:0] ID_EX_Rt,
  input  logic [4:0] ID_EX_Rt_Dst,
  input  logic       ID_EX_MemRead,
  input  logic [4:0] EXE_MEM_Rd,
  input  logic       EXE_MEM_RegWrite,
  input  logic [4:0] MEM_WB_Rd,
  input  logic       MEM_WB_RegWrite,
  output logic [1:0] forwardOp1,
  output logic [1:0] forwardOp2,
  output logic       stall,
  output logic       PC_Write,
  output logic       IF_ID_Write,
  output logic       ID_EX_Flush
`ifdef HFU_STATS_EN
  ,
  output logic [15:0] stall_count,
  output logic [15:0] fwd_count
`endif
);

  // state | meaning
  // RUN   | pipe flowing; a load-use hazard stalls this same cycle
  // HOLD  | remaining stall cycles of a multi-cycle load-use hold
  typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [3:0] HOLD_INIT = (LOAD_LAT > 1) ? 4'(LOAD_LAT - 2) : 4'd0;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       hz;
  logic [1:0] fwd1_raw, fwd2_raw;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic [4:0] mem_rd,
    input logic       mem_we,
    input logic [4:0] wb_rd,
    input logic       wb_we
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (mem_we && (mem_rd != 5'd0) && (mem_rd == src))
      sel = 2'b10;
    else if (wb_we && (wb_rd != 5'd0) && (wb_rd == src))
      sel = 2'b01;
    return sel;
  endfunction

  always_comb begin
    fwd1_raw = fwd_sel(ID_EX_Rs, EXE_MEM_Rd, EXE_MEM_RegWrite, MEM_WB_Rd, MEM_WB_RegWrite);
    fwd2_raw = fwd_sel(ID_EX_Rt, EXE_MEM_Rd, EXE_MEM_RegWrite, MEM_WB_Rd, MEM_WB_RegWrite);
    hz = ID_EX_MemRead && (ID_EX_Rt_Dst != 5'd0) &&
         ((ID_EX_Rt_Dst == IF_ID_Rs) || (ID_EX_Rt_Dst == IF_ID_Rt));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (hz && (LOAD_LAT > 1)) begin
          state_d = HOLD;
          cnt_d   = HOLD_INIT;
        end
      end
      HOLD: begin
        if (cnt_q == 4'd0) state_d = RUN;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: begin
        state_d = RUN;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Outputs are forced to their idle values while reset is held.
  always_comb begin
    stall      = 1'b0;
    forwardOp1 = 2'b00;
    forwardOp2 = 2'b00;
    if (!reset) begin
      forwardOp1 = fwd1_raw;
      forwardOp2 = fwd2_raw;
      case (state_q)
        RUN:     stall = hz;
        HOLD:    stall = 1'b1;
        default: stall = 1'b0;
      endcase
    end
    PC_Write    = !stall;
    IF_ID_Write = !stall;
    ID_EX_Flush = stall;
  end

`ifdef HFU_STATS_EN
  logic [15:0] stall_count_q, stall_count_d;
  logic [15:0] fwd_count_q, fwd_count_d;

  always_comb begin
    stall_count_d = stall_count_q;
    fwd_count_d   = fwd_count_q;
    if (stall && (stall_count_q != 16'hFFFF))
      stall_count_d = stall_count_q + 16'd1;
    if (!stall && ((forwardOp1 != 2'b00) || (forwardOp2 != 2'b00)) && (fwd_count_q != 16'hFFFF))
      fwd_count_d = fwd_count_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count_q <= 16'd0;
      fwd_count_q   <= 16'd0;
    end else begin
      stall_count_q <= stall_count_d;
      fwd_count_q   <= fwd_count_d;
    end
  end

  assign stall_count = stall_count_q;
  assign fwd_count   = fwd_count_q;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: two instances (LOAD_LAT=1 and 3) against a
// behavioural model; define HFU_STATS_EN to also check the activity counters.
module tb_hazard_forward_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] IF_ID_Rs, IF_ID_Rt, ID_EX_Rs, ID_EX_Rt, ID_EX_Rt_Dst;
  logic       ID_EX_MemRead;
  logic [4:0] EXE_MEM_Rd, MEM_WB_Rd;
  logic       EXE_MEM_RegWrite, MEM_WB_RegWrite;

  logic [1:0] f1 [2];
  logic [1:0] f2 [2];
  logic       st [2];
  logic       pcw [2];
  logic       ifw [2];
  logic       fl [2];
`ifdef HFU_STATS_EN
  logic [15:0] sc [2];
  logic [15:0] fc [2];
`endif

  int total = 0;
  int bad   = 0;

  // model state: remaining stall cycles after the current one, plus counters
  int lat [2] = '{1, 3};
  int rem [2] = '{0, 0};
  int m_sc [2] = '{0, 0};
  int m_fc [2] = '{0, 0};

  always #5 clk = ~clk;

  hazard_forward_unit #(.LOAD_LAT(1)) dut1 (
    .clk(clk), .reset(reset),
    .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt),
    .ID_EX_Rs(ID_EX_Rs), .ID_EX_Rt(ID_EX_Rt),
    .ID_EX_Rt_Dst(ID_EX_Rt_Dst), .ID_EX_MemRead(ID_EX_MemRead),
    .EXE_MEM_Rd(EXE_MEM_Rd), .EXE_MEM_RegWrite(EXE_MEM_RegWrite),
    .MEM_WB_Rd(MEM_WB_Rd), .MEM_WB_RegWrite(MEM_WB_RegWrite),
    .forwardOp1(f1[0]), .forwardOp2(f2[0]), .stall(st[0]),
    .PC_Write(pcw[0]), .IF_ID_Write(ifw[0]), .ID_EX_Flush(fl[0])
`ifdef HFU_STATS_EN
    , .stall_count(sc[0]), .fwd_count(fc[0])
`endif
  );

  hazard_forward_unit #(.LOAD_LAT(3)) dut3 (
    .clk(clk), .reset(reset),
    .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt),
    .ID_EX_Rs(ID_EX_Rs), .ID_EX_Rt(ID_EX_Rt),
    .ID_EX_Rt_Dst(ID_EX_Rt_Dst), .ID_EX_MemRead(ID_EX_MemRead),
    .EXE_MEM_Rd(EXE_MEM_Rd), .EXE_MEM_RegWrite(EXE_MEM_RegWrite),
    .MEM_WB_Rd(MEM_WB_Rd), .MEM_WB_RegWrite(MEM_WB_RegWrite),
    .forwardOp1(f1[1]), .forwardOp2(f2[1]), .stall(st[1]),
    .PC_Write(pcw[1]), .IF_ID_Write(ifw[1]), .ID_EX_Flush(fl[1])
`ifdef HFU_STATS_EN
    , .stall_count(sc[1]), .fwd_count(fc[1])
`endif
  );

  function automatic logic [1:0] ref_fwd(input logic [4:0] src);
    if (EXE_MEM_RegWrite && EXE_MEM_Rd != 0 && EXE_MEM_Rd == src) return 2'b10;
    if (MEM_WB_RegWrite && MEM_WB_Rd != 0 && MEM_WB_Rd == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit ref_hz();
    return ID_EX_MemRead && ID_EX_Rt_Dst != 0 &&
           (ID_EX_Rt_Dst == IF_ID_Rs || ID_EX_Rt_Dst == IF_ID_Rt);
  endfunction

  function automatic bit ref_stall(input int i);
    if (reset) return 1'b0;
    return (rem[i] > 0) || ref_hz();
  endfunction

  // advance the model across one rising edge, then step past it
  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        rem[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
      end else begin
        bit s;
        s = ref_stall(i);
        if (s && m_sc[i] < 16'hFFFF) m_sc[i]++;
        if (!s && (ref_fwd(ID_EX_Rs) != 0 || ref_fwd(ID_EX_Rt) != 0) && m_fc[i] < 16'hFFFF) m_fc[i]++;
        if (rem[i] > 0) rem[i]--;
        else if (ref_hz()) rem[i] = lat[i] - 1;
      end
    end
    #1;
  endtask

  task automatic clear_inputs();
    IF_ID_Rs = 0; IF_ID_Rt = 0; ID_EX_Rs = 0; ID_EX_Rt = 0; ID_EX_Rt_Dst = 0;
    ID_EX_MemRead = 0; EXE_MEM_Rd = 0; EXE_MEM_RegWrite = 0; MEM_WB_Rd = 0; MEM_WB_RegWrite = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    ID_EX_MemRead = 1; ID_EX_Rt_Dst = 3; IF_ID_Rs = 3;
    EXE_MEM_Rd = 6; EXE_MEM_RegWrite = 1; ID_EX_Rs = 6; MEM_WB_Rd = 7; MEM_WB_RegWrite = 1; ID_EX_Rt = 7;
    tick(); tick();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      total++;
      if ({f1[i], f2[i], st[i], pcw[i], ifw[i], fl[i]} !== 8'b0000_0110) begin
        bad++;
        $display("FAIL reset[%0d]: got f1=%b f2=%b stall=%b pcw=%b ifw=%b flush=%b, want 00 00 0 1 1 0",
                 i, f1[i], f2[i], st[i], pcw[i], ifw[i], fl[i]);
      end
`ifdef HFU_STATS_EN
      total++;
      if (sc[i] !== 16'd0 || fc[i] !== 16'd0) begin
        bad++;
        $display("FAIL reset_counts[%0d]: got sc=%0d fc=%0d, want 0 0", i, sc[i], fc[i]);
      end
`endif
    end
    tick();
    reset = 1'b0;
    clear_inputs();
  endtask

  task automatic test_forward_directed();
    clear_inputs();
    EXE_MEM_Rd = 5; EXE_MEM_RegWrite = 1; MEM_WB_Rd = 5; MEM_WB_RegWrite = 1; ID_EX_Rs = 5; ID_EX_Rt = 9;
    #1;
    total++;
    if (f1[0] !== 2'b10 || f2[0] !== 2'b00) begin
      bad++;
      $display("FAIL fwd_priority: got f1=%b f2=%b, want 10 00", f1[0], f2[0]);
    end
    clear_inputs();
    MEM_WB_Rd = 7; MEM_WB_RegWrite = 1; ID_EX_Rt = 7; EXE_MEM_Rd = 7; EXE_MEM_RegWrite = 0;
    #1;
    total++;
    if (f2[0] !== 2'b01 || f1[0] !== 2'b00) begin
      bad++;
      $display("FAIL fwd_wb: got f1=%b f2=%b, want 00 01", f1[0], f2[0]);
    end
    MEM_WB_Rd = 0; ID_EX_Rt = 0; EXE_MEM_Rd = 0; EXE_MEM_RegWrite = 1;
    #1;
    total++;
    if (f2[0] !== 2'b00) begin
      bad++;
      $display("FAIL fwd_r0: got f2=%b, want 00", f2[0]);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_load_use();
    for (int c = 0; c < 6; c++) begin
      clear_inputs();
      if (c == 0) begin ID_EX_MemRead = 1; ID_EX_Rt_Dst = 3; IF_ID_Rs = 3; end
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        bit es;
        es = ref_stall(i);
        total++;
        if (st[i] !== es || pcw[i] !== !es || ifw[i] !== !es || fl[i] !== es) begin
          bad++;
          $display("FAIL load_use[lat=%0d c=%0d]: got stall=%b pcw=%b ifw=%b flush=%b, want stall=%b",
                   lat[i], c, st[i], pcw[i], ifw[i], fl[i], es);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_hold();
    clear_inputs();
    ID_EX_MemRead = 1; ID_EX_Rt_Dst = 3; IF_ID_Rt = 3;
    tick();
    clear_inputs();
    @(negedge clk);
    total++;
    if (st[1] !== 1'b1) begin
      bad++;
      $display("FAIL mid_hold_pre: got stall=%b, want 1", st[1]);
    end
    reset = 1'b1;
    for (int i = 0; i < 2; i++) rem[i] = 0;
    #1;
    total++;
    if (st[1] !== 1'b0 || pcw[1] !== 1'b1) begin
      bad++;
      $display("FAIL mid_hold_abort: got stall=%b pcw=%b, want 0 1", st[1], pcw[1]);
    end
    tick();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (st[1] !== 1'b0 || pcw[1] !== 1'b1) begin
        bad++;
        $display("FAIL post_reset[c=%0d]: got stall=%b pcw=%b, want 0 1", c, st[1], pcw[1]);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    ID_EX_MemRead = 1; ID_EX_Rt_Dst = 12; IF_ID_Rs = 12;
    EXE_MEM_Rd = 12; EXE_MEM_RegWrite = 1; ID_EX_Rs = 12;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        total++;
        if (st[i] !== 1'b1 || pcw[i] !== 1'b0 || f1[i] !== 2'b10) begin
          bad++;
          $display("FAIL back_to_back[lat=%0d c=%0d]: got stall=%b pcw=%b f1=%b, want 1 0 10",
                   lat[i], c, st[i], pcw[i], f1[i]);
        end
      end
      tick();
    end
    clear_inputs();
    for (int c = 0; c < 3; c++) tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      IF_ID_Rs = 5'($urandom_range(0, 3)); IF_ID_Rt = 5'($urandom_range(0, 3));
      ID_EX_Rs = 5'($urandom_range(0, 3)); ID_EX_Rt = 5'($urandom_range(0, 3));
      ID_EX_Rt_Dst = 5'($urandom_range(0, 3));
      ID_EX_MemRead = ($urandom_range(0, 3) == 0);
      EXE_MEM_Rd = 5'($urandom_range(0, 3)); EXE_MEM_RegWrite = 1'($urandom);
      MEM_WB_Rd = 5'($urandom_range(0, 3)); MEM_WB_RegWrite = 1'($urandom);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        bit es;
        es = ref_stall(i);
        total++;
        if (f1[i] !== ref_fwd(ID_EX_Rs) || f2[i] !== ref_fwd(ID_EX_Rt) ||
            st[i] !== es || pcw[i] !== !es || ifw[i] !== !es || fl[i] !== es) begin
          bad++;
          $display("FAIL random[lat=%0d c=%0d]: got f1=%b f2=%b stall=%b pcw=%b ifw=%b flush=%b, want f1=%b f2=%b stall=%b",
                   lat[i], c, f1[i], f2[i], st[i], pcw[i], ifw[i], fl[i],
                   ref_fwd(ID_EX_Rs), ref_fwd(ID_EX_Rt), es);
        end
      end
      tick();
    end
    clear_inputs();
`ifdef HFU_STATS_EN
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      total++;
      if (sc[i] !== 16'(m_sc[i]) || fc[i] !== 16'(m_fc[i])) begin
        bad++;
        $display("FAIL random_counts[lat=%0d]: got sc=%0d fc=%0d, want %0d %0d",
                 lat[i], sc[i], fc[i], m_sc[i], m_fc[i]);
      end
    end
`endif
  endtask

`ifdef HFU_STATS_EN
  task automatic test_stats();
    reset = 1'b1;
    clear_inputs();
    tick();
    reset = 1'b0;
    ID_EX_MemRead = 1; ID_EX_Rt_Dst = 3; IF_ID_Rs = 3;
    tick(); tick();
    clear_inputs();
    EXE_MEM_Rd = 4; EXE_MEM_RegWrite = 1; ID_EX_Rt = 4;
    tick(); tick(); tick(); tick();
    clear_inputs();
    @(negedge clk);
    total++;
    if (sc[0] !== 16'd2 || fc[0] !== 16'd4) begin
      bad++;
      $display("FAIL stats: got sc=%0d fc=%0d, want 2 4", sc[0], fc[0]);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_forward_directed();
    test_load_use();
    test_reset_mid_hold();
    test_back_to_back();
    test_random();
`ifdef HFU_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

Control block producing the operand-forwarding select codes (`forwardOp1`, `forwardOp2`) consumed by the EXE-stage operand muxes, plus the load-use stall and bubble controls for the IF/ID/EX pipeline registers of the 5-stage MIPS pipeline. It compares the ID/EX source register numbers against the EXE/MEM and MEM/WB destinations to drive forwarding. A small stall FSM holds the front of the pipe for a configurable number of cycles when a load result is needed by the next instruction.

## Interface
Parameters:
- `LOAD_LAT`, 1, load-use stall length in cycles (legal 1..15)

Ports:
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-high
- `IF_ID_Rs`, `IF_ID_Rt` in 5: source registers of the instruction in ID
- `ID_EX_Rs`, `ID_EX_Rt` in 5: source registers of the instruction in EXE
- `ID_EX_Rt_Dst` in 5: load destination of the instruction in EXE
- `ID_EX_MemRead` in 1: instruction in EXE is a load
- `EXE_MEM_Rd` in 5, `EXE_MEM_RegWrite` in 1: MEM-stage destination and write enable
- `MEM_WB_Rd` in 5, `MEM_WB_RegWrite` in 1: WB-stage destination and write enable
- `forwardOp1`, `forwardOp2` out 2: 00 = register file, 01 = WB_Data, 10 = EXE_MEM_Result; 11 never driven
- `stall` out 1: load-use hold active
- `PC_Write`, `IF_ID_Write` out 1: update enables, low during stall
- `ID_EX_Flush` out 1: insert bubble into ID/EX

## Operation
- Forwarding is combinational from the inputs, and is valid before the rising edge at which the operand muxes sample.
- For each operand X (Rs→Op1, Rt→Op2), the codes are chosen in priority order:
  - 10 if `EXE_MEM_RegWrite` && `EXE_MEM_Rd` != 0 && `EXE_MEM_Rd` == X.
  - Otherwise 01 if `MEM_WB_RegWrite` && `MEM_WB_Rd` != 0 && `MEM_WB_Rd` == X.
  - Otherwise 00.
- Register 0 is never forwarded.
- Load-use hazard `hz` = `ID_EX_MemRead` && `ID_EX_Rt_Dst` != 0 && (`ID_EX_Rt_Dst` == `IF_ID_Rs` || `ID_EX_Rt_Dst` == `IF_ID_Rt`).
- FSM states are RUN and HOLD, with a 4-bit down-counter `cnt`.
- RUN:
  - If `hz` is false, `stall`=0, `PC_Write`=1, `IF_ID_Write`=1, `ID_EX_Flush`=0.
  - If `hz` is true, `stall`=1, `PC_Write`=0, `IF_ID_Write`=0, `ID_EX_Flush`=1 in the same cycle.
  - On `hz`, if `LOAD_LAT`>1 the FSM goes to HOLD with `cnt`=`LOAD_LAT`-2. Otherwise it stays in RUN.
- HOLD:
  - `stall`=1, `PC_Write`=0, `IF_ID_Write`=0, `ID_EX_Flush`=1. `hz` is ignored.
  - When `cnt`==0 the FSM goes to RUN. Otherwise `cnt` decrements.
- Back-to-back loads: after returning to RUN, `hz` is re-evaluated on the then-current inputs. A new hazard starts a new stall immediately.

## Timing
- Forward codes have zero-cycle latency (combinational).
- A stall lasts exactly `LOAD_LAT` cycles, counted from the cycle in which `hz` is first true.
- The cycle after the last stall cycle has `PC_Write`=1, unless a new hazard is present.
- During `reset`, and after it asynchronously asserts:
  - State = RUN, `cnt`=0.
  - `forwardOp1`=`forwardOp2`=00, `stall`=0, `PC_Write`=1, `IF_ID_Write`=1, `ID_EX_Flush`=0.
- Reset asserted mid-HOLD aborts the stall immediately. The first cycle after release is in RUN.
- When EXE_MEM and MEM_WB both match the same source, code 10 wins.
- `hz` true while forwarding also matches: both outputs are driven independently. Forward codes stay live during a stall.

## Configuration
- `HFU_STATS_EN` defined:
  - Adds outputs `stall_count` out 16 and `fwd_count` out 16, both reset to 0.
  - `stall_count` increments on every cycle with `stall`=1.
  - `fwd_count` increments on every cycle in which either forward code is non-zero and `stall`=0.
  - Both counters saturate at 0xFFFF.
- `HFU_STATS_EN` undefined: neither port nor counter exists. Behaviour is otherwise identical.

## Test plan
- EXE_MEM_Rd=5/RegWrite=1, MEM_WB_Rd=5/RegWrite=1, ID_EX_Rs=5 -> forwardOp1=10, forwardOp2=00.
- MEM_WB_Rd=7/RegWrite=1, ID_EX_Rt=7, EXE_MEM_RegWrite=0 -> forwardOp2=01; with Rd=0 and Rt=0 -> 00.
- LOAD_LAT=1: ID_EX_MemRead=1, ID_EX_Rt_Dst=3, IF_ID_Rs=3 for one cycle -> stall=1, PC_Write=0, ID_EX_Flush=1 for exactly 1 cycle.
- LOAD_LAT=3: same hazard -> stall high 3 consecutive cycles, PC_Write returns to 1 on cycle 4.
- LOAD_LAT=3: assert reset in the 2nd stall cycle -> stall=0 and PC_Write=1 immediately; no stall after release with hz false.
- HFU_STATS_EN: 2 stall cycles then 4 cycles with forwardOp2=10 -> stall_count=2, fwd_count=4.
